// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states, access-size codes,
// and the alignment rule used by the fault check (SUBWORD_EN enables sub-word sizes).
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Reserved size 2'b11 falls into the word rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage load/store bus between the pipeline (master) and the data-memory responder (slave).
interface data_mem_responder_if;

    logic        MEM_MemRead;
    logic        MEM_MemWrite;
    logic [31:0] MEM_ALUOut;
    logic [31:0] MEM_RtData;
    logic [1:0]  MEM_Size;
    logic        MEM_Unsigned;
    logic [31:0] Mem_ReadData;
    logic        Mem_Stall;
    logic        Mem_AddrError;

    modport master (
        output MEM_MemRead, MEM_MemWrite, MEM_ALUOut, MEM_RtData, MEM_Size, MEM_Unsigned,
        input  Mem_ReadData, Mem_Stall, Mem_AddrError
    );

    modport slave (
        input  MEM_MemRead, MEM_MemWrite, MEM_ALUOut, MEM_RtData, MEM_Size, MEM_Unsigned,
        output Mem_ReadData, Mem_Stall, Mem_AddrError
    );

endinterface

// File: rtl/mem_byte_lane.sv
// Byte-lane steering for the responder: merges store data into the addressed word and extracts
// and extends load data. With SUBWORD_EN undefined every access is a full word (passthrough).
module mem_byte_lane
    import mem_pkg::*;
(
    input  logic [31:0] cur_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        uns,
    output logic [31:0] merged,
    output logic [31:0] loaded
);

`ifdef SUBWORD_EN
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store merge: only the addressed lane(s) take new data.
    always_comb begin
        merged = cur_word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    2'd3:    merged[31:24] = wdata[7:0];
                    default: merged        = cur_word;
                endcase
            end
            SZ_HALF: begin
                if (offset[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0]  = wdata[15:0];
                end
            end
            default: merged = wdata;
        endcase
    end

    // Lane select for loads.
    always_comb begin
        byte_s = cur_word[7:0];
        case (offset)
            2'd0:    byte_s = cur_word[7:0];
            2'd1:    byte_s = cur_word[15:8];
            2'd2:    byte_s = cur_word[23:16];
            2'd3:    byte_s = cur_word[31:24];
            default: byte_s = cur_word[7:0];
        endcase
        if (offset[1]) begin
            half_s = cur_word[31:16];
        end else begin
            half_s = cur_word[15:0];
        end
    end

    // Load extension: sign unless the unsigned flag is set.
    always_comb begin
        loaded = cur_word;
        case (size)
            SZ_BYTE: loaded = {{24{~uns & byte_s[7]}}, byte_s};
            SZ_HALF: loaded = {{16{~uns & half_s[15]}}, half_s};
            default: loaded = cur_word;
        endcase
    end
`else
    logic unused_s;

    assign merged   = wdata;
    assign loaded   = cur_word;
    assign unused_s = ^{size, offset, uns};
`endif

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory on the MEM-stage load/store bus: stalls the pipeline until each access
// completes and flags misaligned/out-of-range accesses. SUBWORD_EN enables byte/half accesses.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    data_mem_responder_if.slave  bus
);

    localparam int         DEPTH  = 1 << ADDR_W;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    logic [31:0] mem_q [DEPTH];

    state_e      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic              req_s;
    logic              store_s;
    logic              range_err_s;
    logic              misalign_s;
    logic              fault_s;
    logic              we_s;
    logic [ADDR_W-1:0] idx_s;
    logic [31:0]       cur_word_s;
    logic [31:0]       merged_s;
    logic [31:0]       loaded_s;

    // A simultaneous read+write request is a store.
    assign req_s       = bus.MEM_MemRead | bus.MEM_MemWrite;
    assign store_s     = bus.MEM_MemWrite;
    assign range_err_s = (bus.MEM_ALUOut[31:ADDR_W+2] != {(30-ADDR_W){1'b0}});
`ifdef SUBWORD_EN
    assign misalign_s  = is_misaligned(bus.MEM_Size, bus.MEM_ALUOut[1:0]);
`else
    assign misalign_s  = (bus.MEM_ALUOut[1:0] != 2'b00);
`endif
    assign fault_s     = range_err_s | misalign_s;
    assign idx_s       = bus.MEM_ALUOut[ADDR_W+1:2];
    assign cur_word_s  = mem_q[idx_s];

    mem_byte_lane u_lane (
        .cur_word (cur_word_s),
        .wdata    (bus.MEM_RtData),
        .size     (bus.MEM_Size),
        .offset   (bus.MEM_ALUOut[1:0]),
        .uns      (bus.MEM_Unsigned),
        .merged   (merged_s),
        .loaded   (loaded_s)
    );

    // Next-state, wait counter, result register and error pulse.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        we_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    if (fault_s) begin
                        state_d = DONE;
                        rdata_d = 32'h0000_0000;
                        err_d   = 1'b1;
                    end else begin
                        state_d = BUSY;
                        count_d = LAT_M1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end else begin
                    state_d = DONE;
                    if (store_s) begin
                        we_s = 1'b1;
                    end else begin
                        rdata_d = loaded_s;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers; reset aborts any access in flight.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            count_q <= 4'd0;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge Clock) begin
        if (we_s) begin
            mem_q[idx_s] <= merged_s;
        end
    end

    // The stall drops only in DONE so MEM/WB captures exactly once per access.
    assign bus.Mem_Stall     = req_s & (state_q != DONE);
    assign bus.Mem_ReadData  = rdata_q;
    assign bus.Mem_AddrError = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder; byte-addressed reference memory, random traffic.
module tb_data_mem_responder;

    localparam int AW  = 8;
    localparam int LAT = 2;

    logic Clock = 1'b0;
    logic Reset;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0]  mb [0:(4<<AW)-1];
    logic [31:0] last_rdata;

    always #5 Clock = ~Clock;

    data_mem_responder_if bus ();

    data_mem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    // Reference: byte-addressed memory, expected result, error flag and stall-cycle count.
    task automatic model_access(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] data, input logic [1:0] size, input logic uns,
                                output logic [31:0] er, output logic ee, output int es);
        int n;
        logic [31:0] v;
        n = 4;
`ifdef SUBWORD_EN
        if (size == 2'b00) n = 1;
        else if (size == 2'b01) n = 2;
`endif
        if (addr >= (32'd4 << AW) || (addr % n) != 0) begin
            ee = 1'b1; es = 1; last_rdata = 32'h0;
        end else begin
            ee = 1'b0; es = LAT + 1;
            if (wr) begin
                for (int i = 0; i < n; i++) mb[addr + i] = data[8*i +: 8];
            end else if (rd) begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mb[addr + i];
                if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                last_rdata = v;
            end
        end
        er = last_rdata;
    endtask

    // Drive one access (called #1 after a rising edge) and observe it up to its DONE cycle.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [1:0] size, input logic uns,
                             input bit keep, output logic [31:0] r, output logic e,
                             output int stalls, output bit to);
        bus.MEM_MemRead  = rd;
        bus.MEM_MemWrite = wr;
        bus.MEM_ALUOut   = addr;
        bus.MEM_RtData   = data;
        bus.MEM_Size     = size;
        bus.MEM_Unsigned = uns;
        r = 32'h0; e = 1'b0; stalls = 0; to = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clock);
            if (bus.Mem_Stall) begin
                stalls++;
            end else begin
                r = bus.Mem_ReadData; e = bus.Mem_AddrError; to = 1'b0;
                break;
            end
        end
        @(posedge Clock); #1;
        if (!keep) begin
            bus.MEM_MemRead  = 1'b0;
            bus.MEM_MemWrite = 1'b0;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        bus.MEM_MemRead = 1'b0; bus.MEM_MemWrite = 1'b0; bus.MEM_ALUOut = 32'h0;
        bus.MEM_RtData = 32'h0; bus.MEM_Size = 2'b10; bus.MEM_Unsigned = 1'b0;
        last_rdata = 32'h0;
        #12;
        checks++;
        if (bus.Mem_ReadData !== 32'h0 || bus.Mem_AddrError !== 1'b0 || bus.Mem_Stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got rdata=%h err=%b stall=%b exp 0/0/0",
                     bus.Mem_ReadData, bus.Mem_AddrError, bus.Mem_Stall);
        end
        bus.MEM_MemRead = 1'b1; #1;
        checks++;
        if (bus.Mem_Stall !== 1'b1) begin
            failures++; $display("FAIL reset_stall_follows_req got=%b exp=1", bus.Mem_Stall);
        end
        bus.MEM_MemRead = 1'b0;
        @(negedge Clock); Reset = 1'b1;
        @(posedge Clock); #1;
    endtask

    task automatic test_init();
        logic [31:0] r, er, d; logic e, ee; int s, es; bit to;
        for (int w = 0; w < 64; w++) begin
            d = $urandom;
            model_access(1'b0, 1'b1, 32'(4*w), d, 2'b10, 1'b0, er, ee, es);
            do_access(1'b0, 1'b1, 32'(4*w), d, 2'b10, 1'b0, 1'b0, r, e, s, to);
            checks++;
            if (to || r !== er || e !== ee || s !== es) begin
                failures++;
                $display("FAIL init_store w=%0d got r=%h e=%b s=%0d exp r=%h e=%b s=%0d",
                         w, r, e, s, er, ee, es);
            end
        end
    endtask

    task automatic test_store_load();
        logic [31:0] r, er; logic e, ee; int s, es; bit to;
        model_access(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 2'b10, 1'b0, er, ee, es);
        do_access(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0, r, e, s, to);
        checks++;
        if (to || s !== 3 || e !== 1'b0 || r !== er) begin
            failures++; $display("FAIL sw_dead got s=%0d e=%b r=%h exp s=3 e=0 r=%h", s, e, r, er);
        end
        model_access(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, er, ee, es);
        do_access(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 1'b0, r, e, s, to);
        checks++;
        if (to || s !== 3 || e !== 1'b0 || r !== 32'hDEADBEEF) begin
            failures++; $display("FAIL lw_dead got s=%0d e=%b r=%h exp s=3 e=0 r=deadbeef", s, e, r);
        end
    endtask

`ifdef SUBWORD_EN
    task automatic test_subword();
        logic [31:0] r, er; logic e, ee; int s, es; bit to;
        model_access(1'b0, 1'b1, 32'h21, 32'h80, 2'b00, 1'b0, er, ee, es);
        do_access(1'b0, 1'b1, 32'h21, 32'h80, 2'b00, 1'b0, 1'b0, r, e, s, to);
        checks++;
        if (to || e !== 1'b0 || s !== 3) begin
            failures++; $display("FAIL sb_21 got e=%b s=%0d exp e=0 s=3", e, s);
        end
        do_access(1'b1, 1'b0, 32'h21, 32'h0, 2'b00, 1'b0, 1'b0, r, e, s, to);
        checks++;
        if (to || r !== 32'hFFFFFF80) begin
            failures++; $display("FAIL lb_21 got=%h exp=ffffff80", r);
        end
        do_access(1'b1, 1'b0, 32'h21, 32'h0, 2'b00, 1'b1, 1'b0, r, e, s, to);
        checks++;
        if (to || r !== 32'h00000080) begin
            failures++; $display("FAIL lbu_21 got=%h exp=00000080", r);
        end
        model_access(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, er, ee, es);
        do_access(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 1'b0, r, e, s, to);
        checks++;
        if (to || r !== 32'hDEAD80EF || r !== er) begin
            failures++; $display("FAIL lw_after_sb got=%h exp=dead80ef", r);
        end
    endtask
`endif

    task automatic test_misaligned();
        logic [31:0] r, er; logic e, ee; int s, es; bit to;
        do_access(1'b1, 1'b0, 32'h22, 32'h0, 2'b10, 1'b0, 1'b0, r, e, s, to);
        checks++;
        if (to || e !== 1'b1 || r !== 32'h0 || s !== 1) begin
            failures++; $display("FAIL lw_misaligned got e=%b r=%h s=%0d exp e=1 r=0 s=1", e, r, s);
        end
        last_rdata = 32'h0;
        @(negedge Clock);
        checks++;
        if (bus.Mem_AddrError !== 1'b0) begin
            failures++; $display("FAIL err_pulse_width got=%b exp=0", bus.Mem_AddrError);
        end
        @(posedge Clock); #1;
        model_access(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, er, ee, es);
        do_access(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 1'b0, r, e, s, to);
        checks++;
        if (to || r !== er || e !== 1'b0) begin
            failures++; $display("FAIL mem_after_misaligned got=%h exp=%h", r, er);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] r, er; logic e, ee; int s, es; bit to;
        do_access(1'b1, 1'b0, 32'h1 << (AW+2), 32'h0, 2'b10, 1'b0, 1'b0, r, e, s, to);
        checks++;
        if (to || e !== 1'b1 || r !== 32'h0 || s !== 1) begin
            failures++; $display("FAIL lw_oor got e=%b r=%h s=%0d exp e=1 r=0 s=1", e, r, s);
        end
        do_access(1'b0, 1'b1, 32'h1 << (AW+2), 32'hFFFFFFFF, 2'b10, 1'b0, 1'b0, r, e, s, to);
        checks++;
        if (to || e !== 1'b1 || s !== 1) begin
            failures++; $display("FAIL sw_oor got e=%b s=%0d exp e=1 s=1", e, s);
        end
        last_rdata = 32'h0;
        model_access(1'b1, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, er, ee, es);
        do_access(1'b1, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, r, e, s, to);
        checks++;
        if (to || r !== er || e !== 1'b0) begin
            failures++; $display("FAIL word0_after_oor got=%h exp=%h", r, er);
        end
    endtask

    task automatic test_both();
        logic [31:0] r, er; logic e, ee; int s, es; bit to;
        model_access(1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, 2'b10, 1'b0, er, ee, es);
        do_access(1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, 2'b10, 1'b0, 1'b0, r, e, s, to);
        checks++;
        if (to || r !== er || e !== 1'b0 || s !== 3) begin
            failures++; $display("FAIL rd_wr_store got r=%h s=%0d exp r=%h s=3", r, s, er);
        end
        do_access(1'b1, 1'b0, 32'h30, 32'h0, 2'b10, 1'b0, 1'b0, r, e, s, to);
        checks++;
        if (to || r !== 32'hA5A5A5A5) begin
            failures++; $display("FAIL lw_after_rd_wr got=%h exp=a5a5a5a5", r);
        end
        last_rdata = 32'hA5A5A5A5;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, er; logic e, ee; int s, es; bit to;
        model_access(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, er, ee, es);
        do_access(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 1'b1, r, e, s, to);
        checks++;
        if (to || r !== er || s !== 3) begin
            failures++; $display("FAIL b2b_first got r=%h s=%0d exp r=%h s=3", r, s, er);
        end
        model_access(1'b1, 1'b0, 32'h30, 32'h0, 2'b10, 1'b0, er, ee, es);
        do_access(1'b1, 1'b0, 32'h30, 32'h0, 2'b10, 1'b0, 1'b0, r, e, s, to);
        checks++;
        if (to || r !== er || s !== 3) begin
            failures++; $display("FAIL b2b_second got r=%h s=%0d exp r=%h s=3", r, s, er);
        end
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] r, er; logic e, ee; int s, es; bit to;
        model_access(1'b0, 1'b1, 32'h10, 32'h11111111, 2'b10, 1'b0, er, ee, es);
        do_access(1'b0, 1'b1, 32'h10, 32'h11111111, 2'b10, 1'b0, 1'b0, r, e, s, to);
        bus.MEM_MemWrite = 1'b1; bus.MEM_ALUOut = 32'h10; bus.MEM_RtData = 32'h12345678;
        bus.MEM_Size = 2'b10;
        @(negedge Clock); @(negedge Clock);
        #1 Reset = 1'b0;
        #1;
        checks++;
        if (bus.Mem_ReadData !== 32'h0 || bus.Mem_Stall !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset got rdata=%h stall=%b exp 0/1", bus.Mem_ReadData, bus.Mem_Stall);
        end
        bus.MEM_MemWrite = 1'b0;
        last_rdata = 32'h0;
        @(negedge Clock); Reset = 1'b1;
        @(posedge Clock); #1;
        model_access(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, er, ee, es);
        do_access(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, r, e, s, to);
        checks++;
        if (to || r !== 32'h11111111 || r !== er) begin
            failures++; $display("FAIL aborted_store got=%h exp=11111111", r);
        end
    endtask

    task automatic test_random();
        logic [31:0] r, er, a, d; logic e, ee, rd, wr, u; logic [1:0] sz; int s, es; bit to, k;
        for (int n = 0; n < 200; n++) begin
            rd = 1'($urandom); wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            a  = ($urandom_range(0, 9) == 0) ? (32'($urandom) | (32'h1 << (AW+2)))
                                             : 32'($urandom_range(0, 255));
            d  = $urandom; sz = 2'($urandom); u = 1'($urandom);
            k  = (n != 199) && ($urandom_range(0, 2) == 0);
            model_access(rd, wr, a, d, sz, u, er, ee, es);
            do_access(rd, wr, a, d, sz, u, k, r, e, s, to);
            checks++;
            if (to || r !== er || e !== ee || s !== es) begin
                failures++;
                $display("FAIL random n=%0d a=%h sz=%0d rd=%b wr=%b got r=%h e=%b s=%0d exp r=%h e=%b s=%0d",
                         n, a, sz, rd, wr, r, e, s, er, ee, es);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_store_load();
`ifdef SUBWORD_EN
        test_subword();
`endif
        test_misaligned();
        test_out_of_range();
        test_both();
        test_back_to_back();
        test_reset_mid_store();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
